// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// Each BLOCK-bit carry-select slice resolves in its own register stage under a global stall.
module pipelined_csel_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_param
    $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK");
  end

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * BLOCK;
    localparam int unsigned HI  = LO + BLOCK;
    localparam int unsigned REM = WIDTH - HI;

    // Operand bits [WIDTH-1:LO] not yet consumed, plus the incoming carry and partial sum
    logic [WIDTH-LO-1:0] in_a;
    logic [WIDTH-LO-1:0] in_b;
    logic                in_c;
    logic                in_v;
    logic [BLOCK:0]      cand0;
    logic [BLOCK:0]      cand1;
    logic [BLOCK-1:0]    blk_sum;
    logic                blk_cout;
    logic [HI-1:0]       sum_d;

    logic                valid_q;
    logic                carry_q;
    logic [HI-1:0]       sum_q;

    assign cand0 = {1'b0, in_a[BLOCK-1:0]} + {1'b0, in_b[BLOCK-1:0]};
    assign cand1 = {1'b0, in_a[BLOCK-1:0]} + {1'b0, in_b[BLOCK-1:0]} + (BLOCK+1)'(1);
    assign {blk_cout, blk_sum} = in_c ? cand1 : cand0;

    if (k == 0) begin : g_src
      assign in_v  = accept;
      assign in_a  = a;
      assign in_b  = b_eff;
      assign in_c  = c0;
      assign sum_d = blk_sum;
    end else begin : g_src
      assign in_v  = g_stage[k-1].valid_q;
      assign in_a  = g_stage[k-1].g_ops.a_q;
      assign in_b  = g_stage[k-1].g_ops.b_q;
      assign in_c  = g_stage[k-1].carry_q;
      assign sum_d = {blk_sum, g_stage[k-1].sum_q};
    end

    // Data only loads behind a valid token, so bubbles never disturb held results
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (advance) begin
        valid_q <= in_v;
        if (in_v) begin
          carry_q <= blk_cout;
          sum_q   <= sum_d;
        end
      end
    end

    if (REM > 0) begin : g_ops
      logic [REM-1:0] a_q;
      logic [REM-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance && in_v) begin
          a_q <= in_a[WIDTH-LO-1:BLOCK];
          b_q <= in_b[WIDTH-LO-1:BLOCK];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic msb_cin_q;

      // Carry into the MSB recovered from the MSB's sum bit: s = a ^ b ^ c
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          msb_cin_q <= 1'b0;
        end else if (advance && in_v) begin
          msb_cin_q <= in_a[BLOCK-1] ^ in_b[BLOCK-1] ^ blk_sum[BLOCK-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.msb_cin_q ^ g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed bench for pipelined_csel_adder at WIDTH=16, BLOCK=4 (four stages).
// Each step samples outputs just after the falling edge, then drives the next inputs.
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_vec = 0;
  int n_bad = 0;

  pipelined_csel_adder #(
    .WIDTH(16),
    .BLOCK(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected result packed as {cout, ovf, sum}
  function automatic logic [17:0] res(input logic c, input logic o, input logic [15:0] s);
    return {c, o, s};
  endfunction

  task automatic step(input logic dv, input logic [15:0] da, input logic [15:0] db,
                      input logic dcin, input logic dsub, input logic ordy,
                      input logic ev, input logic [17:0] eres, input logic erdy,
                      input string tag);
    @(negedge clk);
    out_ready = ordy;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(erdy));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    if (ev) check({tag, ".result"}, 32'({cout, ovf, sum}), 32'(eres));
    if (dv) begin
      in_valid = 1'b1;
      a = da;
      b = db;
      cin = dcin;
      sub = dsub;
    end else begin
      in_valid = 1'b0;
      a = 'x;
      b = 'x;
      cin = 1'bx;
      sub = 1'bx;
    end
  endtask

  task automatic idle(input logic ev, input logic [17:0] eres, input string tag);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ev, eres, 1'b1, tag);
  endtask

  // One isolated op: result must show after exactly four edges, not earlier
  task automatic single(input logic [15:0] da, input logic [15:0] db, input logic dcin,
                        input logic dsub, input logic [17:0] eres, input string tag);
    step(1'b1, da, db, dcin, dsub, 1'b1, 1'b0, '0, 1'b1, tag);
    repeat (3) idle(1'b0, '0, tag);
    idle(1'b1, eres, tag);
  endtask

  logic [15:0] st_a[8] = '{16'h1111, 16'hABCD, 16'hF0F0, 16'h5000,
                           16'h4000, 16'h0000, 16'h8000, 16'h00FF};
  logic [15:0] st_b[8] = '{16'h2222, 16'h1234, 16'h0F10, 16'h3000,
                           16'h4000, 16'h0001, 16'h8000, 16'h0001};
  logic        st_c[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        st_s[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [17:0] st_e[8] = '{18'h0_3333, 18'h0_BE01, 18'h2_0000, 18'h2_2000,
                           18'h1_8000, 18'h0_FFFF, 18'h3_0000, 18'h0_0101};

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", 32'({cout, ovf, sum}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed single ops
    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, res(1'b1, 1'b0, 16'h0000), "add_ripple");
    single(16'h8000, 16'h0001, 1'b0, 1'b1, res(1'b1, 1'b1, 16'h7FFF), "sub_ovf");
    single(16'h0003, 16'h0005, 1'b0, 1'b1, res(1'b0, 1'b0, 16'hFFFE), "sub_borrow");
    single(16'h0003, 16'h0005, 1'b1, 1'b1, res(1'b0, 1'b0, 16'hFFFE), "sub_cin_ign");
    single(16'h7FFF, 16'h0001, 1'b0, 1'b0, res(1'b0, 1'b1, 16'h8000), "add_ovf");
    single(16'h1234, 16'h0001, 1'b1, 1'b0, res(1'b0, 1'b0, 16'h1236), "add_cin");

    // Back-to-back streaming: one result per cycle, in order
    for (int i = 0; i < 12; i++) begin
      step(i < 8, st_a[i % 8], st_b[i % 8], st_c[i % 8], st_s[i % 8], 1'b1,
           i >= 4, st_e[(i >= 4) ? i - 4 : 0], 1'b1, $sformatf("stream%0d", i));
    end

    // Backpressure with a held offer (E), then a bubble ahead of F
    step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "bp0");
    step(1'b1, 16'h0F00, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "bp1");
    step(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b1, "bp2");
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "bp3");
    for (int i = 4; i < 7; i++) begin
      step(1'b1, 16'h7000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1, res(1'b0, 1'b0, 16'h0003),
           1'b0, $sformatf("bp%0d", i));
    end
    step(1'b1, 16'h7000, 16'h1000, 1'b0, 1'b0, 1'b1, 1'b1, res(1'b0, 1'b0, 16'h0003),
         1'b1, "bp7");
    idle(1'b1, res(1'b0, 1'b0, 16'h1000), "bp8");
    step(1'b1, 16'h2468, 16'h1357, 1'b1, 1'b0, 1'b1, 1'b1, res(1'b1, 1'b0, 16'h0FFF),
         1'b1, "bp9");
    idle(1'b1, res(1'b1, 1'b0, 16'hFFFE), "bp10");
    idle(1'b1, res(1'b0, 1'b1, 16'h8000), "bp11");
    idle(1'b0, '0, "bp12");
    idle(1'b1, res(1'b0, 1'b0, 16'h37C0), "bp13");

    // Reset mid-stream: first result visible and stalled, three more in flight
    step(1'b1, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "mr0");
    step(1'b1, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "mr1");
    step(1'b1, 16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "mr2");
    step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, "mr3");
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, res(1'b0, 1'b0, 16'h0030), 1'b0, "mr4");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.result", 32'({cout, ovf, sum}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) idle(1'b0, '0, $sformatf("post_rst%0d", i));
    single(16'h0001, 16'h0001, 1'b0, 1'b0, res(1'b0, 1'b0, 16'h0002), "post_rst_op");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
